// File: rtl/param_bram.sv
`default_nettype none
// ============================================================================
// Module   : param_bram
// Brief    : Parameterised single-port block RAM with byte-enabled writes,
//            1/2-cycle read latency and a pattern re-initialisation engine.
// Revision : 1.0  initial release
// ============================================================================
module param_bram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int RD_LAT    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    input  logic                init_start,
    output logic                busy,
    output logic                init_done
);
    localparam int              C_NB    = DATA_W / 8;
    localparam int              C_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_READY = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_addr;
    logic                r_init_done;
    logic [DATA_W-1:0]   r_mem  [0:DEPTH-1];
    logic [RD_LAT-1:0]   r_vld;
    logic [DATA_W-1:0]   r_pipe [RD_LAT];

    logic                w_accept;
    logic                w_in_range;
    logic                w_rd;
    logic                w_wr;
    logic                w_pending;
    logic [C_IW-1:0]     w_idx;
    logic [C_IW-1:0]     w_init_idx;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_init_word;

    assign req_ready  = reset && (r_state == S_READY) && !init_start;
    assign busy       = !reset || (r_state != S_READY);
    assign init_done  = r_init_done;
    assign rsp_valid  = r_vld[RD_LAT-1];
    assign rsp_rdata  = r_pipe[RD_LAT-1];

    assign w_accept   = req_valid && req_ready;
    assign w_in_range = {1'b0, req_addr} < C_DEPTH;
    assign w_rd       = w_accept && !req_we;
    assign w_wr       = w_accept && req_we && w_in_range;
    assign w_idx      = req_addr[C_IW-1:0];
    assign w_init_idx = r_init_addr[C_IW-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    always_comb begin
        w_init_word = '0;
        if (INIT_MODE == 1) begin
            w_init_word = DATA_W'(DEPTH - 1 - int'(r_init_addr));
        end else if (INIT_MODE == 2) begin
            w_init_word = DATA_W'(r_init_addr);
        end
    end

    // Only reads that have not yet reached the output stage hold DRAIN open.
    generate
        if (RD_LAT > 1) begin : g_pend
            assign w_pending = |r_vld[RD_LAT-2:0];
        end else begin : g_nopend
            assign w_pending = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset && r_state == S_INIT) begin
            r_mem[w_init_idx] <= w_init_word;
        end else if (w_wr) begin
            for (int k = 0; k < C_NB; k++) begin
                if (req_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Data is captured at the accept edge so later writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_rd;
            r_pipe[0] <= w_rd ? w_rd_word : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_init_addr <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_init_addr <= r_init_addr + ADDR_W'(1);
                    if (r_init_addr == C_LAST) begin
                        r_init_addr <= '0;
                        r_init_done <= 1'b1;
                        r_state     <= S_READY;
                    end
                end
                S_READY: begin
                    if (init_start) begin
                        r_state <= w_pending ? S_DRAIN : S_INIT;
                    end
                end
                S_DRAIN: begin
                    if (!w_pending) begin
                        r_state <= S_INIT;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_bram.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_bram
// Brief    : Self-checking bench for param_bram: scoreboard model on the
//            default instance plus directed checks on RD_LAT=2 and 16-bit ones.
// Revision : 1.0  initial release
// ============================================================================
module tb_param_bram;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic       a_v, a_we, a_is, a_rdy, a_rv, a_busy, a_done;
    logic [7:0] a_addr, a_wd, a_rd;
    logic [0:0] a_be;
    logic       b_v, b_we, b_is, b_rdy, b_rv, b_busy, b_done;
    logic [7:0] b_addr, b_wd, b_rd;
    logic [0:0] b_be;
    logic        c_v, c_we, c_is, c_rdy, c_rv, c_busy, c_done;
    logic [7:0]  c_addr;
    logic [15:0] c_wd, c_rd;
    logic [1:0]  c_be;

    param_bram u_a (
        .clk(clk), .reset(reset), .req_valid(a_v), .req_ready(a_rdy), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wd), .req_be(a_be), .rsp_valid(a_rv),
        .rsp_rdata(a_rd), .init_start(a_is), .busy(a_busy), .init_done(a_done));
    param_bram #(.RD_LAT(2)) u_b (
        .clk(clk), .reset(reset), .req_valid(b_v), .req_ready(b_rdy), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wd), .req_be(b_be), .rsp_valid(b_rv),
        .rsp_rdata(b_rd), .init_start(b_is), .busy(b_busy), .init_done(b_done));
    param_bram #(.DATA_W(16), .INIT_MODE(0), .DEPTH(16)) u_c (
        .clk(clk), .reset(reset), .req_valid(c_v), .req_ready(c_rdy), .req_we(c_we),
        .req_addr(c_addr), .req_wdata(c_wd), .req_be(c_be), .rsp_valid(c_rv),
        .rsp_rdata(c_rd), .init_start(c_is), .busy(c_busy), .init_done(c_done));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard model of the default instance, indexed by cycle number.
    typedef struct { int due; logic [7:0] d; } rsp_t;
    rsp_t       q[$];
    logic [7:0] mm [256];
    int         cyc = 0;
    int         init_left = 0;
    int         done_cyc = -1;
    bit         draining = 0;
    bit         known = 0;

    function automatic bit future(input int n);
        foreach (q[i]) if (q[i].due > n) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int n;
        n   = cyc;
        cyc = cyc + 1;
        if (!reset) begin
            known     = 1;
            init_left = 256;
            draining  = 0;
            done_cyc  = -1;
            q.delete();
        end else if (init_left > 0) begin
            mm[256-init_left] = 8'(init_left - 1);
            init_left--;
            if (init_left == 0) done_cyc = n + 1;
        end else if (draining) begin
            if (!future(n)) begin
                draining  = 0;
                init_left = 256;
            end
        end else begin
            if (a_v && !a_is) begin
                if (a_we) begin
                    if (a_be[0]) mm[a_addr] = a_wd;
                end else begin
                    q.push_back('{due: n + 1, d: mm[a_addr]});
                end
            end
            if (a_is) begin
                if (future(n)) draining = 1;
                else init_left = 256;
            end
        end
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    end

    logic       e_busy, e_rdy, e_rv, e_done;
    logic [7:0] e_rd;
    always @(negedge clk) begin
        if (known) begin
            e_busy = !reset || init_left > 0 || draining;
            e_rdy  = !e_busy && !a_is;
            e_rv   = q.size() > 0 && q[0].due == cyc;
            e_rd   = e_rv ? q[0].d : 8'h00;
            e_done = (done_cyc == cyc);
            chk("m_busy", a_busy, e_busy);
            chk("m_ready", a_rdy, e_rdy);
            chk("m_rsp_valid", a_rv, e_rv);
            chk("m_rsp_rdata", a_rd, e_rd);
            chk("m_init_done", a_done, e_done);
        end
    end

    task automatic da(input logic v, we, input logic [7:0] ad, wd, input logic be, is);
        a_v = v; a_we = we; a_addr = ad; a_wd = wd; a_be = be; a_is = is;
        @(posedge clk); #1;
    endtask
    task automatic db(input logic v, we, input logic [7:0] ad, wd, input logic be, is);
        b_v = v; b_we = we; b_addr = ad; b_wd = wd; b_be = be; b_is = is;
        @(posedge clk); #1;
    endtask
    task automatic dc(input logic v, we, input logic [7:0] ad, input logic [15:0] wd,
                      input logic [1:0] be);
        c_v = v; c_we = we; c_addr = ad; c_wd = wd; c_be = be; c_is = 1'b0;
        @(posedge clk); #1;
    endtask
    task automatic chka(input string nm, input logic v, input logic [7:0] d);
        chk({nm, "_v"}, a_rv, v);
        chk({nm, "_d"}, a_rd, d);
    endtask
    task automatic chkb(input string nm, input logic v, input logic [7:0] d);
        chk({nm, "_v"}, b_rv, v);
        chk({nm, "_d"}, b_rd, d);
    endtask
    task automatic chkc(input string nm, input logic v, input logic [15:0] d);
        chk({nm, "_v"}, c_rv, v);
        chk({nm, "_d"}, c_rd, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, cb, cc, na, nb, nc, cnt;
        reset = 1'b0;
        a_v = 0; a_we = 0; a_addr = 0; a_wd = 0; a_be = 0; a_is = 0;
        b_v = 0; b_we = 0; b_addr = 0; b_wd = 0; b_be = 0; b_is = 0;
        c_v = 0; c_we = 0; c_addr = 0; c_wd = 0; c_be = 0; c_is = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Initial INIT pass on all three instances.
        ca = 0; cb = 0; cc = 0; na = 0; nb = 0; nc = 0;
        for (int k = 0; k < 300; k++) begin
            ca += (a_busy === 1'b1) ? 1 : 0;
            cb += (b_busy === 1'b1) ? 1 : 0;
            cc += (c_busy === 1'b1) ? 1 : 0;
            na += (a_done === 1'b1) ? 1 : 0;
            nb += (b_done === 1'b1) ? 1 : 0;
            nc += (c_done === 1'b1) ? 1 : 0;
            @(posedge clk); #1;
        end
        chk("init_cycles_a", ca, 256);
        chk("init_cycles_b", cb, 256);
        chk("init_cycles_c", cc, 16);
        chk("init_done_a", na, 1);
        chk("init_done_b", nb, 1);
        chk("init_done_c", nc, 1);

        // Back-to-back reads of the descending pattern.
        da(1, 0, 8'h00, 8'h00, 1'b0, 1'b0); chka("r00", 1'b1, 8'hFF);
        da(1, 0, 8'hFF, 8'h00, 1'b0, 1'b0); chka("rFF", 1'b1, 8'h00);
        da(1, 0, 8'h10, 8'h00, 1'b0, 1'b0); chka("r10", 1'b1, 8'hEF);
        da(0, 0, 8'h00, 8'h00, 1'b0, 1'b0); chka("idle", 1'b0, 8'h00);

        // Write then read-after-write; masked write leaves the word intact.
        da(1, 1, 8'h10, 8'hA5, 1'b1, 1'b0); chka("wr_norsp", 1'b0, 8'h00);
        da(1, 0, 8'h10, 8'h00, 1'b0, 1'b0); chka("raw", 1'b1, 8'hA5);
        da(1, 1, 8'h20, 8'h11, 1'b0, 1'b0);
        da(1, 0, 8'h20, 8'h00, 1'b0, 1'b0); chka("be0", 1'b1, 8'hDF);

        // Re-init with a read just completing; requests during INIT are dropped.
        da(1, 1, 8'h03, 8'h00, 1'b1, 1'b0);
        da(1, 0, 8'h03, 8'h00, 1'b0, 1'b0); chka("pre_init", 1'b1, 8'h00);
        da(1, 1, 8'h03, 8'h77, 1'b1, 1'b1);
        chk("reinit_busy", a_busy, 1'b1);
        da(1, 1, 8'h03, 8'h77, 1'b1, 1'b1);
        da(1, 1, 8'h03, 8'h77, 1'b1, 1'b1);
        cnt = 2;
        while (a_busy === 1'b1 && cnt < 400) begin
            cnt++;
            da(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        chk("reinit_cycles", cnt, 256);
        chk("reinit_done", a_done, 1'b1);
        da(1, 0, 8'h03, 8'h00, 1'b0, 1'b0); chka("post_init", 1'b1, 8'hFC);

        // Reset pulse while INIT is at address 100.
        da(0, 0, 8'h00, 8'h00, 1'b0, 1'b1);
        repeat (100) da(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        da(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        cnt = 0;
        while (a_busy === 1'b1 && cnt < 400) begin
            cnt++;
            da(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        chk("rst_init_cycles", cnt, 256);
        chk("rst_init_done", a_done, 1'b1);
        da(1, 0, 8'h64, 8'h00, 1'b0, 1'b0); chka("r64", 1'b1, 8'h9B);
        da(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Two-cycle latency instance: streaming reads.
        db(1, 0, 8'h00, 8'h00, 1'b0, 1'b0); chkb("l2_c1", 1'b0, 8'h00);
        db(1, 0, 8'h01, 8'h00, 1'b0, 1'b0); chkb("l2_c2", 1'b1, 8'hFF);
        db(1, 0, 8'h02, 8'h00, 1'b0, 1'b0); chkb("l2_c3", 1'b1, 8'hFE);
        db(0, 0, 8'h00, 8'h00, 1'b0, 1'b0); chkb("l2_c4", 1'b1, 8'hFD);
        db(0, 0, 8'h00, 8'h00, 1'b0, 1'b0); chkb("l2_c5", 1'b0, 8'h00);

        // Two-cycle latency instance: init_start with a read in flight.
        db(1, 1, 8'h05, 8'h3C, 1'b1, 1'b0);
        db(1, 0, 8'h05, 8'h00, 1'b0, 1'b0); chkb("drain_pre", 1'b0, 8'h00);
        b_v = 1'b0; b_is = 1'b1; #1;
        chk("drain_req_ready", b_rdy, 1'b0);
        @(posedge clk); #1;
        chk("drain_busy", b_busy, 1'b1);
        chkb("drain_rsp", 1'b1, 8'h3C);
        db(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        chkb("drain_after", 1'b0, 8'h00);
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 400) begin
            cnt++;
            db(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        chk("drain_init_cycles", cnt, 256);
        db(1, 0, 8'h05, 8'h00, 1'b0, 1'b0);
        db(0, 0, 8'h00, 8'h00, 1'b0, 1'b0); chkb("drain_reinit", 1'b1, 8'hFA);

        // 16-bit, zero-initialised, 16-word instance.
        dc(1, 1, 8'h05, 16'h1234, 2'b10);
        dc(1, 0, 8'h05, 16'h0000, 2'b00); chkc("be_hi", 1'b1, 16'h1200);
        dc(1, 1, 8'h15, 16'hFFFF, 2'b11);
        dc(1, 0, 8'h05, 16'h0000, 2'b00); chkc("oob_wr", 1'b1, 16'h1200);
        dc(1, 0, 8'h10, 16'h0000, 2'b00); chkc("oob_rd", 1'b1, 16'h0000);
        dc(1, 1, 8'h0F, 16'hBEEF, 2'b11);
        dc(1, 0, 8'h0F, 16'h0000, 2'b00); chkc("last", 1'b1, 16'hBEEF);
        dc(1, 0, 8'h00, 16'h0000, 2'b00); chkc("zero", 1'b1, 16'h0000);
        dc(0, 0, 8'h00, 16'h0000, 2'b00); chkc("c_idle", 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
